core_stream_driver: RTL and testbench

CORE_STREAM_DRIVER -- requirements
Module: core_stream_driver

---
 rtl/core_stream_driver.sv | 119 +++++++++++
 tb/tb_core_stream_driver.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/core_stream_driver.sv
// rtl/core_stream_driver.sv - Stream-to-core job driver: loads DEPTH words, runs the core, streams results out
// Optional START watchdog compiled in by defining CORE_STREAM_DRIVER_TIMEOUT_EN.
module core_stream_driver #(
    parameter int DATA_WIDTH     = 32,
    parameter int DEPTH          = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        s_valid,
    output logic                        s_ready,
    input  logic [DATA_WIDTH-1:0]       s_data,
    output logic                        m_valid,
    input  logic                        m_ready,
    output logic [DATA_WIDTH-1:0]       m_data,
    output logic                        m_last,
    output logic                        core_start,
    input  logic                        core_busy,
    input  logic                        core_done,
    output logic [DATA_WIDTH*DEPTH-1:0] core_in_buf,
    input  logic [DATA_WIDTH*DEPTH-1:0] core_out_buf,
    output logic                        idle,
    output logic                        err_timeout
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

    typedef enum logic [2:0] {ST_LOAD, ST_START, ST_CLEAR, ST_UNLOAD, ST_ERR} state_t;

    state_t                      r_state;
    state_t                      w_next;
    logic [AW-1:0]               r_wr_idx;
    logic [AW-1:0]               r_rd_idx;
    logic                        r_live;
    logic                        r_start_seen;
    logic [DATA_WIDTH*DEPTH-1:0] r_in_buf;
    logic [DATA_WIDTH-1:0]       r_result [DEPTH];
    logic                        w_accept;
    logic                        w_emit;
    logic                        w_done_ok;
    logic                        w_timeout;
    logic                        w_unused;

    // core_busy carries no control meaning here; status only
    assign w_unused = core_busy;

    // r_live holds s_ready off until the first edge after reset release
    assign s_ready     = (r_state == ST_LOAD) && r_live && rst_n;
    assign m_valid     = (r_state == ST_UNLOAD);
    assign m_last      = m_valid && (r_rd_idx == LAST_IDX);
    assign m_data      = m_valid ? r_result[r_rd_idx] : '0;
    assign core_start  = (r_state == ST_START);
    assign core_in_buf = r_in_buf;
    assign idle        = (r_state == ST_LOAD) && (r_wr_idx == '0);

    assign w_accept  = s_valid && s_ready;
    assign w_emit    = m_valid && m_ready;
    assign w_done_ok = core_done && r_start_seen;

`ifdef CORE_STREAM_DRIVER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] r_wait;
    logic          r_err;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wait <= '0;
            r_err  <= 1'b0;
        end else begin
            r_wait <= (r_state == ST_START) ? r_wait + 1'b1 : '0;
            if (w_timeout) r_err <= 1'b1;
        end
    end

    assign w_timeout   = (r_state == ST_START) && !w_done_ok && (r_wait == TW'(TIMEOUT_CYCLES - 1));
    assign err_timeout = r_err;
`else
    assign w_timeout   = 1'b0;
    assign err_timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= ST_LOAD;
            r_wr_idx     <= '0;
            r_rd_idx     <= '0;
            r_live       <= 1'b0;
            r_start_seen <= 1'b0;
        end else begin
            r_state      <= w_next;
            r_live       <= 1'b1;
            // a done already present on the first START cycle is not trusted
            r_start_seen <= (r_state == ST_START);
            if (w_accept) r_wr_idx <= (r_wr_idx == LAST_IDX) ? '0 : r_wr_idx + 1'b1;
            if (w_emit)   r_rd_idx <= (r_rd_idx == LAST_IDX) ? '0 : r_rd_idx + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept) r_in_buf[int'(r_wr_idx)*DATA_WIDTH +: DATA_WIDTH] <= s_data;
        if ((r_state == ST_START) && w_done_ok) begin
            for (int i = 0; i < DEPTH; i++) r_result[i] <= core_out_buf[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_LOAD:   if (w_accept && (r_wr_idx == LAST_IDX)) w_next = ST_START;
            ST_START: begin
                if (w_done_ok)      w_next = ST_CLEAR;
                else if (w_timeout) w_next = ST_ERR;
            end
            ST_CLEAR:  if (!core_done) w_next = ST_UNLOAD;
            ST_UNLOAD: if (w_emit && (r_rd_idx == LAST_IDX)) w_next = ST_LOAD;
            default:   w_next = ST_ERR;
        endcase
    end
endmodule

// File: tb/tb_core_stream_driver.sv
// tb/tb_core_stream_driver.sv - Self-checking bench for core_stream_driver with a behavioural core model
`timescale 1ns/1ps
module tb_core_stream_driver;
    localparam int DW    = 32;
    localparam int DEPTH = 32;
    localparam int TO    = 16;
`ifdef CORE_STREAM_DRIVER_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic                  s_valid = 1'b0;
    logic                  s_ready;
    logic [DW-1:0]         s_data = '0;
    logic                  m_valid;
    logic                  m_ready = 1'b0;
    logic [DW-1:0]         m_data;
    logic                  m_last;
    logic                  core_start;
    logic                  core_busy = 1'b0;
    logic                  core_done = 1'b0;
    logic [DW*DEPTH-1:0]   core_in_buf;
    logic [DW*DEPTH-1:0]   core_out_buf = '0;
    logic                  idle;
    logic                  err_timeout;

    int vectors = 0;
    int miscompares = 0;

    int            core_lat = 8;
    int            core_hold = 1;
    bit            core_never = 1'b0;
    logic [DW-1:0] core_xor = '0;
    int            c_cnt = 0;
    int            h_cnt = 0;

    logic [DW-1:0] cur [DEPTH];
    logic [DW-1:0] nxt [DEPTH];

    core_stream_driver #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
        .core_start(core_start), .core_busy(core_busy), .core_done(core_done),
        .core_in_buf(core_in_buf), .core_out_buf(core_out_buf),
        .idle(idle), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    // Core: done after core_lat start cycles, result = operand ^ core_xor, done held core_hold cycles after start drops
    always @(posedge clk) begin
        if (!rst_n) begin
            core_done <= 1'b0;
            core_busy <= 1'b0;
            c_cnt     <= 0;
            h_cnt     <= 0;
        end else if (core_start && !core_done) begin
            core_busy <= 1'b1;
            c_cnt     <= c_cnt + 1;
            if (!core_never && (c_cnt + 1 >= core_lat)) begin
                core_done <= 1'b1;
                for (int i = 0; i < DEPTH; i++)
                    core_out_buf[i*DW +: DW] <= core_in_buf[i*DW +: DW] ^ core_xor;
            end
        end else if (!core_start && core_done) begin
            if (h_cnt + 1 >= core_hold) begin
                core_done <= 1'b0;
                core_busy <= 1'b0;
                c_cnt     <= 0;
                h_cnt     <= 0;
            end else begin
                h_cnt <= h_cnt + 1;
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic load(input string tag, input int n, output bit idle_ok);
        int idx = 0;
        int cyc = 0;
        idle_ok = 1'b1;
        while (idx < n && cyc < 200) begin
            s_valid = 1'b1;
            s_data  = cur[idx];
            if (idle !== (idx == 0)) idle_ok = 1'b0;
            if (s_ready) idx++;
            @(negedge clk);
            cyc++;
        end
        check({tag, " load_count"}, idx, n);
    endtask

    task automatic run_job(input int lat, input int hold, input int rmode, input bit hold_valid,
                           input logic [DW-1:0] kx, input string tag);
        logic [DW-1:0]       exp_q [$];
        logic [DW*DEPTH-1:0] snap = '0;
        logic [DW-1:0]       prev_data = '0;
        bit f_idle, f_inbuf = 1, f_sready = 1, f_stall = 1, f_mlast = 1, f_dvalid = 1, prev_stall = 0;
        int got = 0, cyc = 0, start_cnt = 0, last_start = -1, first_mv = -1;
        core_lat  = lat;
        core_hold = hold;
        core_xor  = kx;
        for (int i = 0; i < DEPTH; i++) begin
            cur[i] = nxt[i];
            exp_q.push_back(nxt[i] ^ kx);
        end
        for (int i = 0; i < DEPTH; i++) nxt[i] = $urandom;
        load(tag, DEPTH, f_idle);
        s_valid = hold_valid;
        s_data  = nxt[0];
        while (got < DEPTH && cyc < 600) begin
            if (s_ready) f_sready = 1'b0;
            if (idle) f_idle = 1'b0;
            if (core_start) begin
                if (start_cnt == 0) snap = core_in_buf;
                else if (core_in_buf !== snap) f_inbuf = 1'b0;
                start_cnt++;
                last_start = cyc;
            end
            if (m_valid && core_done) f_dvalid = 1'b0;
            if (m_valid && first_mv < 0) first_mv = cyc;
            if (prev_stall && (!m_valid || m_data !== prev_data)) f_stall = 1'b0;
            if (m_last !== (m_valid && got == DEPTH - 1)) f_mlast = 1'b0;
            case (rmode)
                0:       m_ready = 1'b1;
                1:       m_ready = !m_ready;
                default: m_ready = 1'($urandom_range(0, 1));
            endcase
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
            if (m_valid && m_ready) begin
                check({tag, " data"}, m_data, exp_q.pop_front());
                got++;
            end
            @(negedge clk);
            cyc++;
        end
        m_ready = 1'b0;
        check({tag, " words_out"}, got, DEPTH);
        check({tag, " start_cycles"}, start_cnt, lat + 1);
        check({tag, " turnaround"}, first_mv - last_start, hold + 2);
        check({tag, " inbuf_stable"}, f_inbuf, 1);
        check({tag, " sready_low_busy"}, f_sready, 1);
        check({tag, " stall_stable"}, f_stall, 1);
        check({tag, " mlast"}, f_mlast, 1);
        check({tag, " mvalid_vs_done"}, f_dvalid, 1);
        check({tag, " idle_track"}, f_idle, 1);
        check({tag, " back_in_load"}, {idle, s_ready, m_valid}, 3'b110);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit dummy;
        int c;
        for (int i = 0; i < DEPTH; i++) nxt[i] = DW'(i);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst s_ready", s_ready, 0);
        check("rst m_valid", m_valid, 0);
        check("rst m_last", m_last, 0);
        check("rst core_start", core_start, 0);
        check("rst err_timeout", err_timeout, 0);
        rst_n = 1'b1;
        #1;
        check("release s_ready same cycle", s_ready, 0);
        @(negedge clk);
        check("release s_ready next cycle", s_ready, 1);
        check("release idle", idle, 1);

        run_job(8, 1, 0, 1'b0, '0, "echo_inorder");
        for (int i = 0; i < DEPTH; i++) nxt[i] = DW'(i);
        run_job(8, 1, 1, 1'b0, '0, "ready_toggle");
        run_job(8, 3, 2, 1'b0, DW'($urandom), "done_hold3");
        run_job(5, 1, 2, 1'b1, DW'($urandom), "b2b_a");
        run_job(3, 2, 0, 1'b0, DW'($urandom), "b2b_b");
        for (int k = 0; k < 4; k++)
            run_job($urandom_range(1, 12), $urandom_range(1, 4), $urandom_range(0, 2),
                    1'($urandom_range(0, 1)), DW'($urandom), "random_job");

        for (int i = 0; i < DEPTH; i++) cur[i] = $urandom;
        load("midjob", 17, dummy);
        check("midjob idle", idle, 0);
        rst_n   = 1'b0;
        s_valid = 1'b1;
        repeat (2) begin
            @(negedge clk);
            check("midrst s_ready", s_ready, 0);
            check("midrst core_start", core_start, 0);
            check("midrst m_valid", m_valid, 0);
        end
        s_valid = 1'b0;
        rst_n   = 1'b1;
        @(negedge clk);
        check("midrst release idle", idle, 1);
        check("midrst release s_ready", s_ready, 1);
        check("midrst release m_last", m_last, 0);
        run_job(8, 1, 0, 1'b0, DW'($urandom), "fresh_after_rst");

        core_never = 1'b1;
        for (int i = 0; i < DEPTH; i++) cur[i] = $urandom;
        load("timeout", DEPTH, dummy);
        s_valid = 1'b1;
        for (c = 0; c < 40; c++) begin
            check("to core_start", core_start, TO_EN ? (c < TO) : 1'b1);
            check("to err_timeout", err_timeout, TO_EN ? (c >= TO) : 1'b0);
            check("to s_ready", s_ready, 0);
            check("to m_valid", m_valid, 0);
            @(negedge clk);
        end
        rst_n      = 1'b0;
        s_valid    = 1'b0;
        core_never = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_to err_timeout", err_timeout, 0);
        check("post_to idle", idle, 1);
        run_job(8, 1, 2, 1'b0, DW'($urandom), "recover");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
